// File: rtl/drt_scanner.sv
// Wishbone master that walks the device ROM table: reads the header, then
// words 0..3 of every device entry, and hands each entry out on a valid/ready stream.
module drt_scanner #(
    parameter logic [31:0] DRT_BASE_ADR = 32'h0000_0000,
    parameter int          HEADER_SIZE  = 8,
    parameter int          DEV_SIZE     = 8,
    parameter int          MAX_DEVICES  = 16,
    parameter int          TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic        o_wbm_cyc,
    output logic        o_wbm_stb,
    output logic        o_wbm_we,
    output logic [3:0]  o_wbm_sel,
    output logic [31:0] o_wbm_adr,
    output logic [31:0] o_wbm_dat,
    input  logic [31:0] i_wbm_dat,
    input  logic        i_wbm_ack,
    output logic [15:0] o_drt_id,
    output logic [15:0] o_drt_version,
    output logic [31:0] o_num_devices,
    output logic        o_dev_valid,
    input  logic        i_dev_ready,
    output logic [7:0]  o_dev_index,
    output logic [31:0] o_dev_id,
    output logic [31:0] o_dev_info,
    output logic [31:0] o_dev_mem_off,
    output logic [31:0] o_dev_size
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_ACK, S_WAIT_RELEASE, S_ADVANCE, S_EMIT, S_DONE, S_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_hdr;
    logic [1:0]  r_word;
    logic [7:0]  r_dev_idx;
    logic [7:0]  r_tmo;
    logic [15:0] r_drt_id;
    logic [15:0] r_drt_version;
    logic [31:0] r_num_devices;
    logic [31:0] r_dev_id;
    logic [31:0] r_dev_info;
    logic [31:0] r_dev_mem_off;
    logic [31:0] r_dev_size;
    logic        w_idle;
    logic        w_last;
    logic [31:0] w_hdr_adr;
    logic [31:0] w_dev_adr;

    assign w_idle    = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    assign w_last    = ({24'd0, r_dev_idx} == (r_num_devices - 32'd1));
    assign w_hdr_adr = DRT_BASE_ADR + {30'd0, r_word};
    assign w_dev_adr = DRT_BASE_ADR + 32'(HEADER_SIZE) + 32'(DEV_SIZE) * {24'd0, r_dev_idx}
                       + {30'd0, r_word};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (i_start) w_state_nxt = S_REQ;
            S_REQ:                   w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (i_wbm_ack)          w_state_nxt = S_WAIT_RELEASE;
                else if (r_tmo == 8'd1) w_state_nxt = S_ERROR;
            end
            S_WAIT_RELEASE: if (!i_wbm_ack) w_state_nxt = S_ADVANCE;
            S_ADVANCE: begin
                if (r_hdr) begin
                    if (r_word == 2'd0)                           w_state_nxt = S_REQ;
                    else if (r_num_devices > 32'(MAX_DEVICES))     w_state_nxt = S_ERROR;
                    else if (r_num_devices == 32'd0)              w_state_nxt = S_DONE;
                    else                                          w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = (r_word == 2'd3) ? S_EMIT : S_REQ;
                end
            end
            S_EMIT: if (i_dev_ready) w_state_nxt = w_last ? S_DONE : S_REQ;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hdr         <= 1'b0;
            r_word        <= 2'd0;
            r_dev_idx     <= 8'd0;
            r_tmo         <= 8'd0;
            r_drt_id      <= 16'd0;
            r_drt_version <= 16'd0;
            r_num_devices <= 32'd0;
            r_dev_id      <= 32'd0;
            r_dev_info    <= 32'd0;
            r_dev_mem_off <= 32'd0;
            r_dev_size    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_hdr         <= 1'b1;
                        r_word        <= 2'd0;
                        r_dev_idx     <= 8'd0;
                        r_drt_id      <= 16'd0;
                        r_drt_version <= 16'd0;
                        r_num_devices <= 32'd0;
                    end
                end
                S_REQ: r_tmo <= 8'(TIMEOUT);
                S_WAIT_ACK: begin
                    if (i_wbm_ack) begin
                        if (r_hdr) begin
                            if (r_word == 2'd0) begin
                                r_drt_id      <= i_wbm_dat[31:16];
                                r_drt_version <= i_wbm_dat[15:0];
                            end else begin
                                r_num_devices <= i_wbm_dat;
                            end
                        end else begin
                            case (r_word)
                                2'd0:    r_dev_id      <= i_wbm_dat;
                                2'd1:    r_dev_info    <= i_wbm_dat;
                                2'd2:    r_dev_mem_off <= i_wbm_dat;
                                default: r_dev_size    <= i_wbm_dat;
                            endcase
                        end
                    end else begin
                        r_tmo <= r_tmo - 8'd1;
                    end
                end
                S_ADVANCE: begin
                    // Leaving the header switches to device 0, word 0
                    if (r_hdr) begin
                        if (r_word == 2'd0) begin
                            r_word <= 2'd1;
                        end else begin
                            r_hdr     <= 1'b0;
                            r_word    <= 2'd0;
                            r_dev_idx <= 8'd0;
                        end
                    end else if (r_word != 2'd3) begin
                        r_word <= r_word + 2'd1;
                    end
                end
                S_EMIT: begin
                    if (i_dev_ready && !w_last) begin
                        r_dev_idx <= r_dev_idx + 8'd1;
                        r_word    <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus controls decode straight from the state so reset releases them asynchronously
    assign o_wbm_cyc     = (r_state == S_REQ) || (r_state == S_WAIT_ACK);
    assign o_wbm_stb     = o_wbm_cyc;
    assign o_wbm_adr     = o_wbm_cyc ? (r_hdr ? w_hdr_adr : w_dev_adr) : 32'd0;
    assign o_wbm_we      = 1'b0;
    assign o_wbm_sel     = 4'hF;
    assign o_wbm_dat     = 32'd0;
    assign o_busy        = !w_idle;
    assign o_done        = (r_state == S_DONE);
    assign o_error       = (r_state == S_ERROR);
    assign o_dev_valid   = (r_state == S_EMIT);
    assign o_dev_index   = r_dev_idx;
    assign o_dev_id      = r_dev_id;
    assign o_dev_info    = r_dev_info;
    assign o_dev_mem_off = r_dev_mem_off;
    assign o_dev_size    = r_dev_size;
    assign o_drt_id      = r_drt_id;
    assign o_drt_version = r_drt_version;
    assign o_num_devices = r_num_devices;

endmodule

// File: tb/tb_drt_scanner.sv
// Directed bench for drt_scanner: table of scan scenarios against a behavioural
// ROM slave, plus hand-written backpressure and mid-scan reset sequences.
module tb_drt_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_error;
    logic        o_wbm_cyc, o_wbm_stb, o_wbm_we;
    logic [3:0]  o_wbm_sel;
    logic [31:0] o_wbm_adr, o_wbm_dat, i_wbm_dat;
    logic        i_wbm_ack;
    logic [15:0] o_drt_id, o_drt_version;
    logic [31:0] o_num_devices;
    logic        o_dev_valid;
    logic        i_dev_ready = 1'b1;
    logic [7:0]  o_dev_index;
    logic [31:0] o_dev_id, o_dev_info, o_dev_mem_off, o_dev_size;

    always #5 clk = ~clk;

    drt_scanner dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_wbm_cyc(o_wbm_cyc), .o_wbm_stb(o_wbm_stb), .o_wbm_we(o_wbm_we),
        .o_wbm_sel(o_wbm_sel), .o_wbm_adr(o_wbm_adr), .o_wbm_dat(o_wbm_dat),
        .i_wbm_dat(i_wbm_dat), .i_wbm_ack(i_wbm_ack),
        .o_drt_id(o_drt_id), .o_drt_version(o_drt_version), .o_num_devices(o_num_devices),
        .o_dev_valid(o_dev_valid), .i_dev_ready(i_dev_ready), .o_dev_index(o_dev_index),
        .o_dev_id(o_dev_id), .o_dev_info(o_dev_info), .o_dev_mem_off(o_dev_mem_off),
        .o_dev_size(o_dev_size)
    );

    // Behavioural ROM slave: ack after cfg_lat+1 strobed cycles, held until stb drops
    logic [31:0] cfg_word1 = 32'd2;
    int          cfg_lat = 0;
    logic        cfg_noack = 1'b0;
    logic [31:0] cfg_noack_adr = 32'd0;
    logic        s_ack;
    int          s_cnt;

    function automatic logic [31:0] rom(input logic [31:0] a, input logic [31:0] w1);
        if (a == 32'd0)      return 32'h0001_0001;
        else if (a == 32'd1) return w1;
        else                 return 32'hC0DE_0000 + a;
    endfunction

    assign i_wbm_ack = s_ack;
    assign i_wbm_dat = s_ack ? rom(o_wbm_adr, cfg_word1) : 32'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ack <= 1'b0;
            s_cnt <= 0;
        end else if (!o_wbm_stb) begin
            s_ack <= 1'b0;
            s_cnt <= 0;
        end else if (!s_ack && !(cfg_noack && o_wbm_adr == cfg_noack_adr)) begin
            if (s_cnt >= cfg_lat) s_ack <= 1'b1;
            else                  s_cnt <= s_cnt + 1;
        end
    end

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] id, info, off, size;
    } rec_t;

    logic [31:0] rd_q[$];
    rec_t        rec_q[$];
    int          viol_restb = 0, viol_stab = 0, viol_busact = 0, stb_noack_cycles = 0;
    logic        p_stb = 1'b0, p_valid = 1'b0, p_ready = 1'b0;
    rec_t        p_rec, cur;

    always @(negedge clk) begin
        cur = '{idx: o_dev_index, id: o_dev_id, info: o_dev_info, off: o_dev_mem_off,
                size: o_dev_size};
        if (o_wbm_stb && s_ack) rd_q.push_back(o_wbm_adr);
        if (o_wbm_stb && !p_stb && s_ack) viol_restb++;
        if (o_dev_valid && o_wbm_cyc) viol_busact++;
        if (cfg_noack && o_wbm_stb && o_wbm_adr == cfg_noack_adr) stb_noack_cycles++;
        if (p_valid && !p_ready && (!o_dev_valid || cur != p_rec)) viol_stab++;
        if (o_dev_valid && i_dev_ready) rec_q.push_back(cur);
        p_stb   = o_wbm_stb;
        p_valid = o_dev_valid;
        p_ready = i_dev_ready;
        p_rec   = cur;
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (!(o_done || o_error) && k < budget) begin
            step();
            k++;
        end
        n_cmp++;
        if (!(o_done || o_error)) begin
            n_err++;
            $display("FAIL scan_end: no done/error within %0d cycles", budget);
        end
    endtask

    task automatic chk_rec(input int n, input rec_t r);
        logic [31:0] b;
        b = 32'hC0DE_0000 + 32'd8 + 32'd8 * n;
        chk("rec_idx",  {24'd0, r.idx}, n);
        chk("rec_id",   r.id,   b);
        chk("rec_info", r.info, b + 32'd1);
        chk("rec_off",  r.off,  b + 32'd2);
        chk("rec_size", r.size, b + 32'd3);
    endtask

    typedef struct {
        logic [31:0] word1;
        int          lat;
        logic        noack;
        logic [31:0] noack_adr;
        int          exp_reads;
        int          exp_recs;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] exp_adr[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'd2,  0, 1'b0, 32'd0, 10, 2,  1'b1, 1'b0};
        vecs[1] = '{32'd2,  3, 1'b0, 32'd0, 10, 2,  1'b1, 1'b0};
        vecs[2] = '{32'd0,  0, 1'b0, 32'd0, 2,  0,  1'b1, 1'b0};
        vecs[3] = '{32'd17, 1, 1'b0, 32'd0, 2,  0,  1'b0, 1'b1};
        vecs[4] = '{32'd16, 0, 1'b0, 32'd0, 66, 16, 1'b1, 1'b0};
        vecs[5] = '{32'd1,  0, 1'b1, 32'd9, 3,  0,  1'b0, 1'b1};
        vecs[6] = '{32'd3,  2, 1'b0, 32'd0, 14, 3,  1'b1, 1'b0};

        step();
        step();
        chk("rst_busy",  {31'd0, o_busy},    32'd0);
        chk("rst_done",  {31'd0, o_done},    32'd0);
        chk("rst_error", {31'd0, o_error},   32'd0);
        chk("rst_cyc",   {31'd0, o_wbm_cyc}, 32'd0);
        chk("rst_adr",   o_wbm_adr,          32'd0);
        chk("rst_valid", {31'd0, o_dev_valid}, 32'd0);
        chk("rst_ndev",  o_num_devices,      32'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            cfg_word1 = vecs[i].word1;
            cfg_lat = vecs[i].lat;
            cfg_noack = vecs[i].noack;
            cfg_noack_adr = vecs[i].noack_adr;
            i_dev_ready = 1'b1;
            rd_q.delete();
            rec_q.delete();
            stb_noack_cycles = 0;
            pulse_start();
            wait_end(3000);
            step();
            chk("v_done",  {31'd0, o_done},    {31'd0, vecs[i].exp_done});
            chk("v_error", {31'd0, o_error},   {31'd0, vecs[i].exp_err});
            chk("v_busy",  {31'd0, o_busy},    32'd0);
            chk("v_cyc",   {31'd0, o_wbm_cyc}, 32'd0);
            chk("v_stb",   {31'd0, o_wbm_stb}, 32'd0);
            chk("v_nreads", rd_q.size(),  vecs[i].exp_reads);
            chk("v_nrecs",  rec_q.size(), vecs[i].exp_recs);
            chk("v_drt_id", {16'd0, o_drt_id},      32'h0001);
            chk("v_drt_ver", {16'd0, o_drt_version}, 32'h0001);
            chk("v_ndev",   o_num_devices, vecs[i].word1);
            exp_adr.delete();
            exp_adr.push_back(32'd0);
            exp_adr.push_back(32'd1);
            if (vecs[i].word1 >= 1 && vecs[i].word1 <= 16)
                for (int n = 0; n < int'(vecs[i].word1); n++)
                    for (int k = 0; k < 4; k++)
                        exp_adr.push_back(32'd8 + 32'd8 * n + k);
            for (int j = 0; j < rd_q.size() && j < vecs[i].exp_reads; j++)
                chk("v_adr", rd_q[j], exp_adr[j]);
            for (int n = 0; n < rec_q.size() && n < vecs[i].exp_recs; n++)
                chk_rec(n, rec_q[n]);
            if (vecs[i].noack) begin
                n_cmp++;
                if (stb_noack_cycles < 255 || stb_noack_cycles > 257) begin
                    n_err++;
                    $display("FAIL timeout_len: stb held %0d cycles, expected about 256",
                             stb_noack_cycles);
                end
            end
        end
        cfg_noack = 1'b0;

        // Backpressure: hold record 0 for 20 cycles
        cfg_word1 = 32'd2;
        cfg_lat = 0;
        i_dev_ready = 1'b0;
        rd_q.delete();
        rec_q.delete();
        pulse_start();
        for (int k = 0; k < 200 && !o_dev_valid; k++) step();
        chk("bp_valid0", {31'd0, o_dev_valid}, 32'd1);
        repeat (20) step();
        chk("bp_valid20", {31'd0, o_dev_valid}, 32'd1);
        chk("bp_index",   {24'd0, o_dev_index}, 32'd0);
        chk("bp_id",      o_dev_id, 32'hC0DE_0008);
        chk("bp_nrecs0",  rec_q.size(), 32'd0);
        chk("bp_nreads",  rd_q.size(), 32'd6);
        i_dev_ready = 1'b1;
        step();
        chk("bp_nrecs1",  rec_q.size(), 32'd1);
        chk("bp_drop",    {31'd0, o_dev_valid}, 32'd0);
        wait_end(500);
        chk("bp_done",    {31'd0, o_done}, 32'd1);
        chk("bp_nrecs2",  rec_q.size(), 32'd2);
        if (rec_q.size() == 2) begin
            chk_rec(0, rec_q[0]);
            chk_rec(1, rec_q[1]);
        end

        // Reset while waiting for the ack of address 16
        cfg_lat = 5;
        rd_q.delete();
        rec_q.delete();
        pulse_start();
        for (int k = 0; k < 300 && !(o_wbm_stb && o_wbm_adr == 32'd16); k++) step();
        chk("rs_at16", o_wbm_adr, 32'd16);
        step();
        step();
        #1 rst = 1'b0;
        #1;
        chk("rs_cyc",   {31'd0, o_wbm_cyc}, 32'd0);
        chk("rs_stb",   {31'd0, o_wbm_stb}, 32'd0);
        chk("rs_adr",   o_wbm_adr, 32'd0);
        chk("rs_busy",  {31'd0, o_busy}, 32'd0);
        chk("rs_ndev",  o_num_devices, 32'd0);
        chk("rs_drtid", {16'd0, o_drt_id}, 32'd0);
        #2 rst = 1'b1;
        rd_q.delete();
        repeat (10) step();
        chk("rs_idle",   {31'd0, o_busy}, 32'd0);
        chk("rs_noread", rd_q.size(), 32'd0);
        cfg_lat = 0;
        pulse_start();
        wait_end(500);
        chk("rs_done",  {31'd0, o_done}, 32'd1);
        chk("rs_reads", rd_q.size(), 32'd10);

        chk("restrobe_viol", viol_restb, 32'd0);
        chk("stable_viol",   viol_stab, 32'd0);
        chk("busact_viol",   viol_busact, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/drt_scanner.md
Name: drt_scanner

Overview:
- Wishbone master that walks the device ROM table (DRT) after a start pulse and reads the header and every device entry.
- Presents header fields on static outputs and each device entry as a record on a valid/ready stream.
- Sits directly upstream of the DRT slave and drives its wishbone slave port, either point-to-point or through the interconnect.
- Its record stream feeds the host-side enumeration logic.

Parameters:
- DRT_BASE_ADR, 32'h00000000, word address of DRT word 0.
- HEADER_SIZE, 8, header length in 32-bit words.
- DEV_SIZE, 8, words per device entry.
- MAX_DEVICES, 16, largest legal device count; 1..255.
- TIMEOUT, 255, cycles to wait for an ack before declaring an error; 8-bit counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- i_start  in  1  pulse; begins a scan when the block is idle, done or in error.
- o_busy  out  1  high while a scan is in progress.
- o_done  out  1  high after a successful scan until the next start.
- o_error  out  1  high after a failed scan until the next start.
- o_wbm_cyc  out  1  wishbone cycle.
- o_wbm_stb  out  1  wishbone strobe.
- o_wbm_we  out  1  tied 0.
- o_wbm_sel  out  4  tied 4'hF.
- o_wbm_adr  out  32  word address.
- o_wbm_dat  out  32  tied 0.
- i_wbm_dat  in  32  read data.
- i_wbm_ack  in  1  acknowledge.
- o_drt_id  out  16  header word0[31:16].
- o_drt_version  out  16  header word0[15:0].
- o_num_devices  out  32  header word1.
- o_dev_valid  out  1  record valid.
- i_dev_ready  in  1  consumer accepts the record.
- o_dev_index  out  8  device number, 0-based.
- o_dev_id  out  32  entry word +0.
- o_dev_info  out  32  entry word +1.
- o_dev_mem_off  out  32  entry word +2.
- o_dev_size  out  32  entry word +3.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; internal counters 0; state IDLE.
- States: IDLE, REQ, WAIT_ACK, WAIT_RELEASE, ADVANCE, EMIT, DONE, ERROR.
- Start:
  - i_start in IDLE, DONE or ERROR goes to REQ.
  - On start: clear o_done, o_error and the header outputs; set word pointer to header word 0.
  - o_busy=1 in every state except IDLE, DONE and ERROR.
  - i_start is ignored while busy.
- REQ:
  - Drive cyc=1, stb=1, adr=current address.
  - Go to WAIT_ACK the next cycle.
- WAIT_ACK:
  - Hold cyc and stb until i_wbm_ack=1.
  - On ack: capture i_wbm_dat into the target field, drop stb and cyc in the same registered update, and go to WAIT_RELEASE.
  - The slave holds ack until it sees stb low. The master must never re-strobe while ack is still high.
  - Timeout counter counts cycles in WAIT_ACK. Reaching TIMEOUT → ERROR with cyc=stb=0.
- WAIT_RELEASE: stay until i_wbm_ack=0, then go to ADVANCE. Minimum one cycle. There is no timeout here.
- Read order: header word 0, header word 1, then for each device n words BASE+HEADER_SIZE+n*DEV_SIZE+{0,1,2,3}. Entry words 4..DEV_SIZE-1 are never read.
- ADVANCE after word 1:
  - num_devices > MAX_DEVICES → ERROR.
  - num_devices = 0 → DONE.
  - Otherwise start device 0 word 0.
- ADVANCE after a device word 3 → EMIT.
- EMIT:
  - Assert o_dev_valid; record fields and o_dev_index stay stable until i_dev_ready=1.
  - Transfer happens on a cycle where valid&ready is high. On transfer: drop valid and go to the next device's REQ, or to DONE when index = num_devices-1.
  - No record is ever dropped or duplicated.
- Address arithmetic: 32-bit, modulo 2^32; device index 8-bit.
- DONE: o_done=1.
- ERROR: o_error=1; header outputs keep the values captured so far; o_dev_valid=0.
- Reset mid-scan: bus released immediately and asynchronously (cyc=stb=0); everything returns to IDLE.

Test Plan:
- Header {16'h0001,16'h0001}, word1=2, zero-wait ack slave, start pulse:
  - 10 reads at adr 0,1,8,9,10,11,16,17,18,19.
  - Two records, index 0 and 1, with correct fields.
  - o_done=1, o_busy=0.
- Slave that holds ack high until stb drops, 3-cycle ack latency: stb never reasserts while ack=1; every read completes once.
- Consumer holds i_dev_ready=0 for 20 cycles on record 0: valid stays high with stable fields; no bus activity; transfer happens on the ready cycle.
- word1=0: exactly 2 bus reads, no records, done; word1=17 with MAX_DEVICES=16: error after 2 reads, no records.
- Slave never acks the read at adr 9: ERROR after 255 cycles, cyc=stb=0, no record emitted; a new start rescans from adr 0.
- rst low during WAIT_ACK of adr 16: outputs 0 in the same cycle; after release the block stays idle until i_start.
